// File: rtl/wb_stage_pipe_if.sv
// Handshake and payload bundle between the LSU stage, the MEM->WB pipe register and writeback.
interface wb_stage_pipe_if #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [XLEN-1:0]  pc_i;
  logic [ILEN-1:0]  instr_i;
  logic [XLEN-1:0]  alures_i;
  logic [XLEN-1:0]  lsres_i;
  logic             wben_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  pc_o;
  logic [ILEN-1:0]  instr_o;
  logic [XLEN-1:0]  alures_o;
  logic [XLEN-1:0]  lsres_o;
  logic             wben_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output flush_i, in_valid_i, pc_i, instr_i, alures_i, lsres_i, wben_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, instr_o, alures_o, lsres_o, wben_o, stall_cnt_o
  );

  modport slave (
    input  flush_i, in_valid_i, pc_i, instr_i, alures_i, lsres_i, wben_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, instr_o, alures_o, lsres_o, wben_o, stall_cnt_o
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// MEM->WB handshaked pipeline register with optional skid entry, flush and stall counter.
//   state | meaning
//   EMPTY | no entry held, output is a bubble
//   ONE   | main entry valid on the outputs
//   FULL  | main and skid entries valid, upstream back-pressured
module wb_stage_pipe #(
  parameter int XLEN    = 64,
  parameter int ILEN    = 32,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  wb_stage_pipe_if.slave     bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state;
  logic [XLEN-1:0]  pc_q, alures_q, lsres_q;
  logic [ILEN-1:0]  instr_q;
  logic             wben_q;
  logic [XLEN-1:0]  skid_pc, skid_alures, skid_lsres;
  logic [ILEN-1:0]  skid_instr;
  logic             skid_wben;
  logic             ready_q;
  logic [CNT_W-1:0] stall_q;

  logic out_valid, in_ready, acc, rel;

  assign out_valid = (state != EMPTY);
  // Without the skid entry, ready has to see out_ready combinationally to sustain full rate.
  assign in_ready  = (SKID_EN != 0) ? ready_q : (~out_valid | bus.out_ready_i);
  assign acc       = bus.in_valid_i & in_ready;
  assign rel       = out_valid & bus.out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      ready_q     <= 1'b1;
      stall_q     <= '0;
      pc_q        <= '0;
      instr_q     <= '0;
      alures_q    <= '0;
      lsres_q     <= '0;
      wben_q      <= 1'b0;
      skid_pc     <= '0;
      skid_instr  <= '0;
      skid_alures <= '0;
      skid_lsres  <= '0;
      skid_wben   <= 1'b0;
    end else begin
      if (out_valid && !bus.out_ready_i && stall_q != {CNT_W{1'b1}})
        stall_q <= stall_q + 1'b1;

      if (bus.flush_i) begin
        state   <= EMPTY;
        ready_q <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (acc) begin
              pc_q     <= bus.pc_i;
              instr_q  <= bus.instr_i;
              alures_q <= bus.alures_i;
              lsres_q  <= bus.lsres_i;
              wben_q   <= bus.wben_i;
              state    <= ONE;
            end
          end
          ONE: begin
            if (acc && rel) begin
              pc_q     <= bus.pc_i;
              instr_q  <= bus.instr_i;
              alures_q <= bus.alures_i;
              lsres_q  <= bus.lsres_i;
              wben_q   <= bus.wben_i;
            end else if (acc && SKID_EN != 0) begin
              skid_pc     <= bus.pc_i;
              skid_instr  <= bus.instr_i;
              skid_alures <= bus.alures_i;
              skid_lsres  <= bus.lsres_i;
              skid_wben   <= bus.wben_i;
              state       <= FULL;
              ready_q     <= 1'b0;
            end else if (rel) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            if (rel) begin
              pc_q     <= skid_pc;
              instr_q  <= skid_instr;
              alures_q <= skid_alures;
              lsres_q  <= skid_lsres;
              wben_q   <= skid_wben;
              state    <= ONE;
              ready_q  <= 1'b1;
            end
          end
          default: begin
            state   <= EMPTY;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.pc_o        = pc_q;
  assign bus.instr_o     = instr_q;
  assign bus.alures_o    = alures_q;
  assign bus.lsres_o     = lsres_q;
  assign bus.wben_o      = wben_q & out_valid;
  assign bus.stall_cnt_o = stall_q;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Drives three pipe variants (skid, no skid, 4-bit counter) with shared stimulus and checks each
// against a queue model of a small FIFO, plus hand-computed expectations for the key scenarios.
module tb_wb_stage_pipe;
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, wben;
  logic [63:0] pc, alu, ls;
  logic [31:0] instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage_pipe_if #(.XLEN(64), .ILEN(32), .CNT_W(16)) ifa ();
  wb_stage_pipe_if #(.XLEN(64), .ILEN(32), .CNT_W(16)) ifb ();
  wb_stage_pipe_if #(.XLEN(64), .ILEN(32), .CNT_W(4))  ifc ();

  wb_stage_pipe #(.XLEN(64), .ILEN(32), .SKID_EN(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  wb_stage_pipe #(.XLEN(64), .ILEN(32), .SKID_EN(0), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  wb_stage_pipe #(.XLEN(64), .ILEN(32), .SKID_EN(1), .CNT_W(4))  dut_c (.clk(clk), .rst(rst), .bus(ifc));

  assign ifa.flush_i = flush;  assign ifb.flush_i = flush;  assign ifc.flush_i = flush;
  assign ifa.in_valid_i = in_valid;  assign ifb.in_valid_i = in_valid;  assign ifc.in_valid_i = in_valid;
  assign ifa.out_ready_i = out_ready;  assign ifb.out_ready_i = out_ready;  assign ifc.out_ready_i = out_ready;
  assign ifa.pc_i = pc;  assign ifb.pc_i = pc;  assign ifc.pc_i = pc;
  assign ifa.instr_i = instr;  assign ifb.instr_i = instr;  assign ifc.instr_i = instr;
  assign ifa.alures_i = alu;  assign ifb.alures_i = alu;  assign ifc.alures_i = alu;
  assign ifa.lsres_i = ls;  assign ifb.lsres_i = ls;  assign ifc.lsres_i = ls;
  assign ifa.wben_i = wben;  assign ifb.wben_i = wben;  assign ifc.wben_i = wben;

  logic        d_valid [3];
  logic        d_ready [3];
  logic        d_wben  [3];
  logic [63:0] d_pc    [3];
  logic [31:0] d_instr [3];
  logic [63:0] d_alu   [3];
  logic [63:0] d_ls    [3];
  logic [15:0] d_stall [3];

  assign d_valid[0] = ifa.out_valid_o;  assign d_valid[1] = ifb.out_valid_o;  assign d_valid[2] = ifc.out_valid_o;
  assign d_ready[0] = ifa.in_ready_o;  assign d_ready[1] = ifb.in_ready_o;  assign d_ready[2] = ifc.in_ready_o;
  assign d_wben[0] = ifa.wben_o;  assign d_wben[1] = ifb.wben_o;  assign d_wben[2] = ifc.wben_o;
  assign d_pc[0] = ifa.pc_o;  assign d_pc[1] = ifb.pc_o;  assign d_pc[2] = ifc.pc_o;
  assign d_instr[0] = ifa.instr_o;  assign d_instr[1] = ifb.instr_o;  assign d_instr[2] = ifc.instr_o;
  assign d_alu[0] = ifa.alures_o;  assign d_alu[1] = ifb.alures_o;  assign d_alu[2] = ifc.alures_o;
  assign d_ls[0] = ifa.lsres_o;  assign d_ls[1] = ifb.lsres_o;  assign d_ls[2] = ifc.lsres_o;
  assign d_stall[0] = ifa.stall_cnt_o;  assign d_stall[1] = ifb.stall_cnt_o;
  assign d_stall[2] = {12'd0, ifc.stall_cnt_o};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: each variant is a FIFO of capacity 2 (skid) or 1; the outputs show the oldest entry,
  // or the last entry shown once the FIFO drains.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] alu;
    logic [63:0] ls;
    logic        wben;
  } ent_t;

  ent_t q [3][2];
  ent_t shown [3];
  int   n [3];
  int   stall [3];
  int   stall_max [3] = '{65535, 65535, 15};
  bit   skid [3] = '{1'b1, 1'b0, 1'b1};
  bit   model_ok = 1'b0;

  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      bit er;
      bit acc;
      bit rel;
      er = skid[k] ? (n[k] < 2) : (n[k] == 0 || out_ready);
      if (model_ok) begin
        chk($sformatf("out_valid[%0d]", k), 64'(d_valid[k]), 64'(n[k] > 0));
        chk($sformatf("in_ready[%0d]", k), 64'(d_ready[k]), 64'(er));
        chk($sformatf("wben[%0d]", k), 64'(d_wben[k]), 64'(n[k] > 0 && shown[k].wben));
        chk($sformatf("pc[%0d]", k), d_pc[k], shown[k].pc);
        chk($sformatf("instr[%0d]", k), 64'(d_instr[k]), 64'(shown[k].instr));
        chk($sformatf("alures[%0d]", k), d_alu[k], shown[k].alu);
        chk($sformatf("lsres[%0d]", k), d_ls[k], shown[k].ls);
        chk($sformatf("stall_cnt[%0d]", k), 64'(d_stall[k]), 64'(stall[k]));
      end
      if (rst) begin
        n[k] = 0;
        stall[k] = 0;
        shown[k] = '0;
      end else begin
        acc = in_valid && er;
        rel = (n[k] > 0) && out_ready;
        if (n[k] > 0 && !out_ready && stall[k] < stall_max[k]) stall[k]++;
        if (flush) begin
          n[k] = 0;
        end else begin
          if (rel) begin
            q[k][0] = q[k][1];
            n[k]--;
          end
          if (acc) begin
            q[k][n[k]] = '{pc: pc, instr: instr, alu: alu, ls: ls, wben: wben};
            n[k]++;
          end
        end
        if (n[k] > 0) shown[k] = q[k][0];
      end
    end
    if (rst) model_ok = 1'b1;
  end

  task automatic drive(input bit v, input logic [63:0] p, input bit ordy, input bit fl);
    @(negedge clk);
    in_valid  = v;
    pc        = p;
    instr     = p[31:0] ^ 32'h0000_0013;
    alu       = p * 3;
    ls        = ~p;
    wben      = ~p[2];
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc = '0; instr = '0; alu = '0; ls = '0; wben = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) drive(1'b0, 64'd0, 1'b0, 1'b0);
    #3;
    chk("rst out_valid", 64'(ifa.out_valid_o), 64'd0);
    chk("rst wben", 64'(ifa.wben_o), 64'd0);
    chk("rst in_ready", 64'(ifa.in_ready_o), 64'd1);
    chk("rst pc", ifa.pc_o, 64'd0);
    chk("rst lsres", ifa.lsres_o, 64'd0);
    chk("rst stall", 64'(ifa.stall_cnt_o), 64'd0);

    // Streaming at full rate, outputs one cycle behind.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b1, 1'b0);
      #3;
      if (i > 0) chk("stream pc", ifa.pc_o, 64'h8000_0000 + 64'(4 * (i - 1)));
    end
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    #3;
    chk("stream last pc", ifa.pc_o, 64'h8000_001c);
    chk("stream stall", 64'(ifa.stall_cnt_o), 64'd0);

    // Skid fill and drain, in order.
    reset_dut();
    drive(1'b1, 64'h100, 1'b0, 1'b0);
    drive(1'b1, 64'h104, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    #3;
    chk("full in_ready", 64'(ifa.in_ready_o), 64'd0);
    chk("full pc", ifa.pc_o, 64'h100);
    chk("full stall", 64'(ifa.stall_cnt_o), 64'd1);
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    #3;
    chk("drain A pc", ifa.pc_o, 64'h100);
    chk("drain stall", 64'(ifa.stall_cnt_o), 64'd2);
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    #3;
    chk("drain B pc", ifa.pc_o, 64'h104);
    chk("drain in_ready", 64'(ifa.in_ready_o), 64'd1);
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    #3;
    chk("drained valid", 64'(ifa.out_valid_o), 64'd0);
    chk("drained stall", 64'(ifa.stall_cnt_o), 64'd2);

    // Flush from FULL with a concurrent offer.
    drive(1'b1, 64'h300, 1'b0, 1'b0);
    drive(1'b1, 64'h304, 1'b0, 1'b0);
    drive(1'b1, 64'h200, 1'b0, 1'b1);
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    #3;
    chk("flush valid", 64'(ifa.out_valid_o), 64'd0);
    chk("flush wben", 64'(ifa.wben_o), 64'd0);
    chk("flush in_ready", 64'(ifa.in_ready_o), 64'd1);
    chk("flush stale pc", ifa.pc_o, 64'h300);
    repeat (3) drive(1'b0, 64'd0, 1'b1, 1'b0);

    // Stall counter saturation.
    reset_dut();
    drive(1'b1, 64'h400, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 64'd0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    #3;
    chk("sat stall cnt4", 64'(ifc.stall_cnt_o), 64'd15);
    chk("sat stall cnt16", 64'(ifa.stall_cnt_o), 64'd20);

    // No-skid variant: ready follows out_ready in the same cycle.
    #1;
    chk("noskid ready low", 64'(ifb.in_ready_o), 64'd0);
    drive(1'b1, 64'h500, 1'b1, 1'b0);
    #3;
    chk("noskid ready high", 64'(ifb.in_ready_o), 64'd1);
    for (int i = 1; i < 6; i++) drive(1'b1, 64'h500 + 64'(4 * i), 1'b1, 1'b0);
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    #3;
    chk("noskid pass pc", ifb.pc_o, 64'h514);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 199) < 1);
      pc        = {$urandom, $urandom};
      instr     = $urandom;
      alu       = {$urandom, $urandom};
      ls        = {$urandom, $urandom};
      wben      = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
